// File: rtl/tt_um_akaur014_serial_subtractor_if.sv
// Bit-level bundle between the tile pins and the serial subtract core.
// The master side presents operand bits and framing; the slave side returns results.
interface tt_um_akaur014_serial_subtractor_if;
    logic       a;
    logic       b;
    logic       bit_valid;
    logic       start;
    logic       diff_bit;
    logic       borrow;
    logic       busy;
    logic       done;
    logic       diff_valid;
    logic [7:0] result;

    modport master (
        output a, b, bit_valid, start,
        input  diff_bit, borrow, busy, done,
        input  diff_valid, result
    );

    modport slave (
        input  a, b, bit_valid, start,
        output diff_bit, borrow, busy, done,
        output diff_valid, result
    );
endinterface

// File: rtl/tt_um_akaur014_serial_subtractor.sv
// Bit-serial subtractor tile: D = A - B, LSB first, one bit per accepted cycle.
// A borrow flop links the bits; the final borrow flags A < B.
module sub_stage #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    tt_um_akaur014_serial_subtractor_if.slave s
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(WIDTH - 1);
    localparam logic [7:0] MASK = 8'((9'd1 << WIDTH) - 9'd1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic       borrow_q;
    logic [7:0] result_q;
    logic       diff_q;
    logic       dv_q;
    logic       clr;
    logic       acc;
    logic       d;
    logic       nb;

    assign clr = ena & s.start;
    assign acc = ena & (state_q == SHIFT)
               & s.bit_valid & ~s.start;
    assign d   = s.a ^ s.b ^ borrow_q;
    assign nb  = (~s.a & s.b)
               | (~(s.a ^ s.b) & borrow_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                IDLE:  if (s.start) state_d = SHIFT;
                SHIFT: begin
                    if (s.start)
                        state_d = SHIFT;
                    else if (s.bit_valid && cnt_q == LAST)
                        state_d = DONE;
                end
                DONE:  if (s.start) state_d = SHIFT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        s.busy = 1'b0;
        s.done = 1'b0;
        unique case (state_q)
            SHIFT:   s.busy = 1'b1;
            DONE:    s.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            result_q <= '0;
            diff_q   <= 1'b0;
            dv_q     <= 1'b0;
        end else if (ena) begin
            dv_q <= 1'b0;
            unique case (1'b1)
                clr: begin
                    cnt_q    <= '0;
                    borrow_q <= 1'b0;
                    result_q <= '0;
                end
                acc: begin
                    result_q[cnt_q[2:0]] <= d;
                    borrow_q <= nb;
                    diff_q   <= d;
                    cnt_q    <= cnt_q + 4'd1;
                    dv_q     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pulse is masked rather than cleared so a frozen tile keeps its state.
    assign s.diff_valid = dv_q & ena;
    assign s.diff_bit   = diff_q;
    assign s.borrow     = borrow_q;
    assign s.result     = result_q & MASK;
endmodule

module tt_um_akaur014_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    tt_um_akaur014_serial_subtractor_if bus ();

    logic unused_ok;

    assign bus.a         = ui_in[0];
    assign bus.b         = ui_in[1];
    assign bus.bit_valid = ui_in[2];
    assign bus.start     = ui_in[3];

    sub_stage #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .s     (bus)
    );

    assign uo_out = {3'b000, bus.diff_valid,
                     bus.done, bus.busy,
                     bus.borrow, bus.diff_bit};
    assign uio_out = bus.result;
    assign uio_oe  = 8'hFF;

    assign unused_ok = &{1'b0, ui_in[7:4], uio_in};
endmodule

// File: tb/tb_tt_um_akaur014_serial_subtractor.sv
// Directed bench for the serial subtractor tile.
// Expected words and borrows are hand-computed constants.
module tb_tt_um_akaur014_serial_subtractor;
    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_akaur014_serial_subtractor_if tbif ();

    assign ui_in = {4'b0000, tbif.start, tbif.bit_valid,
                    tbif.b, tbif.a};
    assign tbif.diff_bit   = uo_out[0];
    assign tbif.borrow     = uo_out[1];
    assign tbif.busy       = uo_out[2];
    assign tbif.done       = uo_out[3];
    assign tbif.diff_valid = uo_out[4];
    assign tbif.result     = uio_out;

    tt_um_akaur014_serial_subtractor dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        tbif.a         = 1'b0;
        tbif.b         = 1'b0;
        tbif.bit_valid = 1'b0;
        tbif.start     = 1'b0;
    endtask

    task automatic do_start(input string tag);
        idle_in();
        tbif.start = 1'b1;
        tick();
        tbif.start = 1'b0;
        chk({tag, "_busy"}, {7'd0, uo_out[2]}, 8'd1);
        chk({tag, "_done"}, {7'd0, uo_out[3]}, 8'd0);
        chk({tag, "_clr"}, uio_out, 8'h00);
    endtask

    task automatic bits(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] b,
                        input logic [7:0] d,
                        input int lo,
                        input int hi,
                        input bit gap);
        for (int i = lo; i <= hi; i++) begin
            tbif.a         = a[i];
            tbif.b         = b[i];
            tbif.bit_valid = 1'b1;
            tick();
            chk($sformatf("%s_dv%0d", tag, i),
                {7'd0, uo_out[4]}, 8'd1);
            chk($sformatf("%s_db%0d", tag, i),
                {7'd0, uo_out[0]}, {7'd0, d[i]});
            chk($sformatf("%s_dn%0d", tag, i),
                {7'd0, uo_out[3]},
                {7'd0, (i == 7)});
            if (gap) begin
                tbif.bit_valid = 1'b0;
                tbif.a = ~tbif.a;
                tick();
                chk($sformatf("%s_gap%0d", tag, i),
                    {7'd0, uo_out[4]}, 8'd0);
                chk($sformatf("%s_gdn%0d", tag, i),
                    {7'd0, uo_out[3]},
                    {7'd0, (i == 7)});
            end
        end
        tbif.bit_valid = 1'b0;
    endtask

    task automatic fin(input string tag,
                       input logic [7:0] d,
                       input logic bw);
        chk({tag, "_res"}, uio_out, d);
        chk({tag, "_bw"}, {7'd0, uo_out[1]}, {7'd0, bw});
        chk({tag, "_done"}, {7'd0, uo_out[3]}, 8'd1);
        chk({tag, "_busy"}, {7'd0, uo_out[2]}, 8'd0);
    endtask

    initial begin
        idle_in();
        uio_in = 8'h00;
        ena    = 1'b1;
        rst_n  = 1'b0;
        tick();
        tick();
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("oe", uio_oe, 8'hFF);
        rst_n = 1'b1;
        tick();

        do_start("t1");
        bits("t1", 8'hFF, 8'h00, 8'hFF, 0, 2, 1'b0);
        chk("t1_part", uio_out, 8'h07);
        rst_n = 1'b0;
        #2;
        chk("t1_async_uo", uo_out, 8'h00);
        chk("t1_async_uio", uio_out, 8'h00);
        tick();
        rst_n = 1'b1;
        tbif.a = 1'b1;
        tbif.bit_valid = 1'b1;
        tick();
        tick();
        chk("t1_nostart_uio", uio_out, 8'h00);
        chk("t1_nostart_uo", uo_out, 8'h00);
        idle_in();
        tick();

        do_start("t2");
        bits("t2", 8'h05, 8'h03, 8'h02, 0, 7, 1'b0);
        fin("t2", 8'h02, 1'b0);
        tbif.bit_valid = 1'b1;
        tick();
        chk("t2_ign_dv", {7'd0, uo_out[4]}, 8'd0);
        chk("t2_ign_res", uio_out, 8'h02);
        idle_in();

        do_start("t3");
        bits("t3", 8'h03, 8'h05, 8'hFE, 0, 7, 1'b0);
        fin("t3", 8'hFE, 1'b1);

        do_start("t4");
        bits("t4", 8'h05, 8'h03, 8'h02, 0, 7, 1'b1);
        fin("t4", 8'h02, 1'b0);

        do_start("t5");
        bits("t5", 8'hFF, 8'h00, 8'hFF, 0, 2, 1'b0);
        chk("t5_part", uio_out, 8'h07);
        tbif.a = 1'b1;
        tbif.bit_valid = 1'b1;
        tbif.start = 1'b1;
        tick();
        idle_in();
        chk("t5_rst_res", uio_out, 8'h00);
        chk("t5_rst_bw", {7'd0, uo_out[1]}, 8'd0);
        chk("t5_rst_dv", {7'd0, uo_out[4]}, 8'd0);
        chk("t5_rst_busy", {7'd0, uo_out[2]}, 8'd1);
        bits("t5", 8'h10, 8'h01, 8'h0F, 0, 7, 1'b0);
        fin("t5", 8'h0F, 1'b0);

        do_start("t6");
        bits("t6", 8'hFF, 8'h01, 8'hFE, 0, 2, 1'b0);
        chk("t6_part", uio_out, 8'h06);
        ena = 1'b0;
        tbif.a = 1'b1;
        tbif.bit_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_frz_res%0d", k),
                uio_out, 8'h06);
            chk($sformatf("t6_frz_dv%0d", k),
                {7'd0, uo_out[4]}, 8'd0);
            chk($sformatf("t6_frz_busy%0d", k),
                {7'd0, uo_out[2]}, 8'd1);
        end
        ena = 1'b1;
        bits("t6", 8'hFF, 8'h01, 8'hFE, 3, 7, 1'b0);
        fin("t6", 8'hFE, 1'b0);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end
endmodule
